alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, bit-serial shifts (one bit per cycle),
// and a valid/ready handshake on both the request and the result side.
module alu_seq #(
  parameter int          WIDTH   = 8,
  parameter logic [31:0] ERR_VAL = 32'h0000_00EE
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_func,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_alu,
  output logic             o_err,
  output logic             o_zero,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int               CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    C_CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0]    C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_B_MAX   = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] C_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_FOUR    = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [WIDTH-1:0] C_ERR     = ERR_VAL[WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    OUT   = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_alu;
  logic             r_err;
  logic             r_zero;
  logic             r_valid;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_func;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_is_shift;
  logic [CW-1:0]    w_cnt_ld;
  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;
  logic             w_load_out;
  logic [WIDTH-1:0] w_out_val;
  logic             w_out_err;

  assign w_sum      = {1'b0, i_a} + {1'b0, i_b};
  assign w_is_shift = (i_func == 4'b0100) || (i_func == 4'b0101) || (i_func == 4'b0110);
  assign w_cnt_ld   = (i_b >= C_B_MAX) ? C_CNT_MAX : i_b[CW-1:0];

  // Single-cycle result for every non-shift opcode
  always_comb begin
    w_res = C_ZERO;
    w_err = 1'b0;
    case (i_func)
      4'b0000: w_res = i_a & i_b;
      4'b0001: w_res = i_a | i_b;
      4'b0010: begin
        if (w_sum[WIDTH]) begin
          w_res = C_ERR;
          w_err = 1'b1;
        end else begin
          w_res = w_sum[WIDTH-1:0];
        end
      end
      4'b0011: begin
        if (i_a < i_b) begin
          w_res = C_ERR;
          w_err = 1'b1;
        end else begin
          w_res = i_a - i_b;
        end
      end
      4'b0111: w_res = i_a ^ i_b;
      4'b1000: w_res = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
      4'b1001: w_res = {{(WIDTH-1){1'b0}}, (i_a >= i_b)};
      4'b1010: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      4'b1011: w_res = i_a + {i_b[WIDTH-2:0], 1'b0};
      4'b1100: w_res = i_a + C_FOUR;
      4'b1101: w_res = i_a - C_FOUR;
      4'b1110: w_res = (i_a > i_b) ? i_a : C_ZERO;
      4'b1111: w_res = (i_a < i_b) ? i_a : C_ZERO;
      default: w_res = C_ZERO;
    endcase
  end

  // One-bit step of the captured shift opcode
  always_comb begin
    case (r_func)
      4'b0100: w_shifted = {r_work[WIDTH-2:0], 1'b0};
      4'b0101: w_shifted = {1'b0, r_work[WIDTH-1:1]};
      4'b0110: w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shifted = r_work;
    endcase
  end

  // Next-state logic and result-load selection
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_load_out = 1'b0;
    w_out_val  = r_alu;
    w_out_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_accept = 1'b1;
          if (!w_is_shift) begin
            w_next     = OUT;
            w_load_out = 1'b1;
            w_out_val  = w_res;
            w_out_err  = w_err;
          end else if (w_cnt_ld == {CW{1'b0}}) begin
            w_next     = OUT;
            w_load_out = 1'b1;
            w_out_val  = i_a;
          end else begin
            w_next = SHIFT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        // The edge that takes the counter to zero applies the final shift
        if (r_cnt <= C_CNT_ONE) begin
          w_next     = OUT;
          w_load_out = 1'b1;
          w_out_val  = w_shifted;
        end else begin
          w_next = SHIFT;
        end
      end
      OUT: begin
        if (i_ready) begin
          w_next = IDLE;
        end else begin
          w_next = OUT;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu   <= C_ZERO;
      r_err   <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_work  <= C_ZERO;
      r_cnt   <= {CW{1'b0}};
      r_func  <= 4'b0000;
    end else begin
      r_valid <= (w_next == OUT);
      if (w_accept) begin
        r_work <= i_a;
        r_cnt  <= w_cnt_ld;
        r_func <= i_func;
      end else if (r_state == SHIFT) begin
        r_work <= w_shifted;
        r_cnt  <= r_cnt - C_CNT_ONE;
      end
      if (w_load_out) begin
        r_alu  <= w_out_val;
        r_err  <= w_out_err;
        r_zero <= (w_out_val == C_ZERO);
      end
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_alu   = r_alu;
  assign o_err   = r_err;
  assign o_zero  = r_zero;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8, ERR_VAL=8'hEE.
module tb_alu_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_a = 8'h00;
  logic [7:0] i_b = 8'h00;
  logic [3:0] i_func = 4'b0000;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_ready;
  logic [7:0] o_alu;
  logic       o_err;
  logic       o_zero;
  logic       o_valid;

  int n_err = 0;
  int n_chk = 0;

  alu_seq #(.WIDTH(8), .ERR_VAL(32'h0000_00EE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_b(i_b), .i_func(i_func),
    .i_valid(i_valid), .o_ready(o_ready), .o_alu(o_alu), .o_err(o_err),
    .o_zero(o_zero), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic [7:0] r;
    logic       e;
    int         lat;
  } vec_t;

  vec_t logic_v [13] = '{
    '{8'h0F, 8'h3C, 4'b0000, 8'h0C, 1'b0, 1},
    '{8'h0F, 8'h3C, 4'b0001, 8'h3F, 1'b0, 1},
    '{8'hAA, 8'hFF, 4'b0111, 8'h55, 1'b0, 1},
    '{8'h12, 8'h12, 4'b1000, 8'h01, 1'b0, 1},
    '{8'h12, 8'h13, 4'b1000, 8'h00, 1'b0, 1},
    '{8'h05, 8'h05, 4'b1001, 8'h01, 1'b0, 1},
    '{8'h04, 8'h05, 4'b1001, 8'h00, 1'b0, 1},
    '{8'h05, 8'h05, 4'b1010, 8'h00, 1'b0, 1},
    '{8'h04, 8'h05, 4'b1010, 8'h01, 1'b0, 1},
    '{8'h80, 8'h7F, 4'b1110, 8'h80, 1'b0, 1},
    '{8'h10, 8'h10, 4'b1110, 8'h00, 1'b0, 1},
    '{8'h03, 8'h09, 4'b1111, 8'h03, 1'b0, 1},
    '{8'h09, 8'h03, 4'b1111, 8'h00, 1'b0, 1}
  };

  vec_t arith_v [10] = '{
    '{8'hF0, 8'h20, 4'b0010, 8'hEE, 1'b1, 1},
    '{8'hF0, 8'h0F, 4'b0010, 8'hFF, 1'b0, 1},
    '{8'h80, 8'h80, 4'b0010, 8'hEE, 1'b1, 1},
    '{8'h03, 8'h05, 4'b0011, 8'hEE, 1'b1, 1},
    '{8'h05, 8'h05, 4'b0011, 8'h00, 1'b0, 1},
    '{8'h10, 8'h01, 4'b0011, 8'h0F, 1'b0, 1},
    '{8'h10, 8'h90, 4'b1011, 8'h30, 1'b0, 1},
    '{8'hFE, 8'h00, 4'b1100, 8'h02, 1'b0, 1},
    '{8'hFC, 8'h55, 4'b1100, 8'h00, 1'b0, 1},
    '{8'h02, 8'h00, 4'b1101, 8'hFE, 1'b0, 1}
  };

  vec_t shift_v [7] = '{
    '{8'h90, 8'd3,   4'b0110, 8'hF2, 1'b0, 4},
    '{8'h90, 8'd0,   4'b0110, 8'h90, 1'b0, 1},
    '{8'hFF, 8'd200, 4'b0100, 8'h00, 1'b0, 9},
    '{8'h80, 8'd7,   4'b0101, 8'h01, 1'b0, 8},
    '{8'h80, 8'd255, 4'b0110, 8'hFF, 1'b0, 9},
    '{8'h01, 8'd4,   4'b0100, 8'h10, 1'b0, 5},
    '{8'hF0, 8'd9,   4'b0101, 8'h00, 1'b0, 9}
  };

  // Issue one request from IDLE and count cycles until o_valid (bounded)
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                       output int lat);
    i_a = a; i_b = b; i_func = f; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    n_chk++;
    if ({o_alu, o_err, o_zero, o_valid, o_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: alu=%h err=%b zero=%b valid=%b ready=%b, want 00 0 0 0 1",
               o_alu, o_err, o_zero, o_valid, o_ready);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_logic();
    int lat;
    for (int i = 0; i < 13; i++) begin
      do_op(logic_v[i].a, logic_v[i].b, logic_v[i].f, lat);
      n_chk++;
      if (o_alu !== logic_v[i].r || o_err !== 1'b0 || o_zero !== (logic_v[i].r == 8'h00)) begin
        n_err++;
        $display("FAIL logic[%0d]: alu=%h err=%b zero=%b, want %h 0 %b", i, o_alu, o_err,
                 o_zero, logic_v[i].r, (logic_v[i].r == 8'h00));
      end
      n_chk++;
      if (lat != logic_v[i].lat) begin
        n_err++;
        $display("FAIL logic_lat[%0d]: got %0d want %0d", i, lat, logic_v[i].lat);
      end
      retire();
    end
  endtask

  task automatic test_arith();
    int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(arith_v[i].a, arith_v[i].b, arith_v[i].f, lat);
      n_chk++;
      if (o_alu !== arith_v[i].r || o_err !== arith_v[i].e || o_zero !== (arith_v[i].r == 8'h00)) begin
        n_err++;
        $display("FAIL arith[%0d]: alu=%h err=%b zero=%b, want %h %b %b", i, o_alu, o_err,
                 o_zero, arith_v[i].r, arith_v[i].e, (arith_v[i].r == 8'h00));
      end
      n_chk++;
      if (lat != arith_v[i].lat) begin
        n_err++;
        $display("FAIL arith_lat[%0d]: got %0d want %0d", i, lat, arith_v[i].lat);
      end
      retire();
    end
  endtask

  task automatic test_shift();
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(shift_v[i].a, shift_v[i].b, shift_v[i].f, lat);
      n_chk++;
      if (o_alu !== shift_v[i].r || o_err !== 1'b0 || o_zero !== (shift_v[i].r == 8'h00)) begin
        n_err++;
        $display("FAIL shift[%0d]: alu=%h err=%b zero=%b, want %h 0 %b", i, o_alu, o_err,
                 o_zero, shift_v[i].r, (shift_v[i].r == 8'h00));
      end
      n_chk++;
      if (lat != shift_v[i].lat) begin
        n_err++;
        $display("FAIL shift_lat[%0d]: got %0d want %0d", i, lat, shift_v[i].lat);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(8'h0F, 8'h3C, 4'b0000, lat);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_a = 8'h11 * i[7:0];
      i_b = 8'hFF - i[7:0];
      i_func = 4'b0001;
      @(posedge i_clk); #1;
      n_chk++;
      if ({o_alu, o_err, o_zero, o_valid, o_ready} !== {8'h0C, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: alu=%h err=%b zero=%b valid=%b ready=%b, want 0c 0 0 1 0",
                 i, o_alu, o_err, o_zero, o_valid, o_ready);
      end
    end
    i_valid = 1'b0;
    retire();
    n_chk++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1", o_valid, o_ready);
    end
    @(posedge i_clk); #1;
    n_chk++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_accept: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(8'h01, 8'h02, 4'b0010, lat);
    i_a = 8'h0F; i_b = 8'h3C; i_func = 4'b0001;
    i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    n_chk++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_alu !== 8'h03) begin
      n_err++;
      $display("FAIL b2b_retire: valid=%b ready=%b alu=%h, want 0 1 03", o_valid, o_ready, o_alu);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n_chk++;
    if (o_valid !== 1'b1 || o_alu !== 8'h3F) begin
      n_err++;
      $display("FAIL b2b_accept: valid=%b alu=%h, want 1 3f", o_valid, o_alu);
    end
    retire();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    i_a = 8'h01; i_b = 8'd7; i_func = 4'b0100; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    n_chk++;
    if (o_ready !== 1'b0 || o_alu !== 8'h3F) begin
      n_err++;
      $display("FAIL mid_shift_pre: ready=%b alu=%h, want 0 3f", o_ready, o_alu);
    end
    i_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_alu, o_err, o_zero, o_valid, o_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: alu=%h err=%b zero=%b valid=%b ready=%b, want 00 0 0 0 1",
               o_alu, o_err, o_zero, o_valid, o_ready);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (8) @(posedge i_clk);
    #1;
    n_chk++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL aborted_shift: valid=%b ready=%b, want 0 1", o_valid, o_ready);
    end
    do_op(8'h0F, 8'h3C, 4'b0000, lat);
    n_chk++;
    if (o_alu !== 8'h0C || lat != 1) begin
      n_err++;
      $display("FAIL post_reset_and: alu=%h lat=%0d, want 0c 1", o_alu, lat);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
